// File: rtl/ov7670_capture_pkg.sv
// Shared types and constants for the OV7670 capture front end.
package ov7670_capture_pkg;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_WAIT_SOF,
    ST_ACTIVE
  } state_t;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned RGB565_W     = 16;
  localparam int unsigned BYTE_W       = 8;

endpackage

// File: rtl/cam_edge_det.sv
// Registers one camera sync input and flags its rising/falling edges
// by comparing the registered value with its one-cycle-delayed copy.
module cam_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  output logic x_r,
  output logic rise_c,
  output logic fall_c
);

  logic x_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r <= 1'b0;
      x_d <= 1'b0;
    end else begin
      x_r <= x;
      x_d <= x_r;
    end
  end

  assign rise_c = x_r & ~x_d;
  assign fall_c = ~x_r & x_d;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 byte-pair to RGB565 assembler feeding the async FIFO write side,
// with frame delimiting, drop-on-full and per-frame geometry checking.
module ov7670_capture
  import ov7670_capture_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                vsync,
  input  logic                href,
  input  logic [BYTE_W-1:0]   d,
  input  logic                full,
  output logic                w_en,
  output logic [RGB565_W-1:0] w_data,
  output logic                sof,
  output logic                eof,
  output logic                overflow,
  output logic                frame_err
);

  localparam int unsigned PIX_W  = $clog2(H_ACTIVE + 1);
  localparam int unsigned LINE_W = $clog2(V_ACTIVE + 1);
  localparam logic [PIX_W-1:0]  PIX_MAX     = '1;
  localparam logic [LINE_W-1:0] LINE_MAX    = '1;
  localparam logic [PIX_W-1:0]  PIX_TARGET  = PIX_W'(H_ACTIVE);
  localparam logic [LINE_W-1:0] LINE_TARGET = LINE_W'(V_ACTIVE);

  logic              vsync_r, vsync_rise, vsync_fall;
  logic              href_r, href_rise, href_fall;
  logic [BYTE_W-1:0] d_r;

  state_t            state_q, state_next;
  logic              phase_q, phase_next, phase_eff;
  logic [BYTE_W-1:0] hi_q, hi_next;
  logic [PIX_W-1:0]  pix_q, pix_next;
  logic [LINE_W-1:0] line_q, line_next;
  logic              err_q, err_next;

  logic                w_en_next, sof_next, eof_next, overflow_next, frame_err_next;
  logic [RGB565_W-1:0] w_data_next;

  cam_edge_det u_vsync_det (
    .clk    (wclk),
    .rst_n  (wrst_n),
    .x      (vsync),
    .x_r    (vsync_r),
    .rise_c (vsync_rise),
    .fall_c (vsync_fall)
  );

  cam_edge_det u_href_det (
    .clk    (wclk),
    .rst_n  (wrst_n),
    .x      (href),
    .x_r    (href_r),
    .rise_c (href_rise),
    .fall_c (href_fall)
  );

  // Input stage for the data byte, aligned with the registered syncs
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) d_r <= '0;
    else         d_r <= d;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q   <= ST_SYNC;
      phase_q   <= 1'b0;
      hi_q      <= '0;
      pix_q     <= '0;
      line_q    <= '0;
      err_q     <= 1'b0;
      w_en      <= 1'b0;
      w_data    <= '0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_next;
      phase_q   <= phase_next;
      hi_q      <= hi_next;
      pix_q     <= pix_next;
      line_q    <= line_next;
      err_q     <= err_next;
      w_en      <= w_en_next;
      w_data    <= w_data_next;
      sof       <= sof_next;
      eof       <= eof_next;
      overflow  <= overflow_next;
      frame_err <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_q;
    phase_next     = phase_q;
    phase_eff      = 1'b0;
    hi_next        = hi_q;
    pix_next       = pix_q;
    line_next      = line_q;
    err_next       = err_q;
    w_en_next      = 1'b0;
    w_data_next    = w_data;
    sof_next       = 1'b0;
    eof_next       = 1'b0;
    overflow_next  = overflow;
    frame_err_next = frame_err;

    unique case (state_q)
      ST_SYNC: begin
        if (vsync_r) state_next = ST_WAIT_SOF;
      end

      ST_WAIT_SOF: begin
        if (vsync_fall) begin
          state_next    = ST_ACTIVE;
          sof_next      = 1'b1;
          overflow_next = 1'b0;
          pix_next      = '0;
          line_next     = '0;
          err_next      = 1'b0;
          phase_next    = 1'b0;
        end
      end

      ST_ACTIVE: begin
        // Byte pairing; the first byte of every line restarts the phase
        if (href_r && !vsync_r) begin
          phase_eff  = href_rise ? 1'b0 : phase_q;
          phase_next = ~phase_eff;
          if (!phase_eff) begin
            hi_next = d_r;
          end else begin
            pix_next = (pix_q == PIX_MAX) ? pix_q : pix_q + PIX_W'(1);
            if (full) begin
              overflow_next = 1'b1;
            end else begin
              w_en_next   = 1'b1;
              w_data_next = {hi_q, d_r};
            end
          end
        end

        // Line close precedes the frame check so a coincident vsync rise sees it
        if (href_fall) begin
          err_next   = err_q | phase_q | (pix_q != PIX_TARGET);
          line_next  = (line_q == LINE_MAX) ? line_q : line_q + LINE_W'(1);
          pix_next   = '0;
          phase_next = 1'b0;
        end

        if (vsync_rise) begin
          eof_next       = 1'b1;
          frame_err_next = err_next | (line_next != LINE_TARGET);
          state_next     = ST_WAIT_SOF;
        end
      end

      default: state_next = ST_SYNC;
    endcase
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture with a 4x2 frame geometry.
module tb_ov7670_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync, href, full;
  logic [7:0]  d;
  logic        w_en, sof, eof, overflow, frame_err;
  logic [15:0] w_data;

  int n_checks = 0;
  int n_pass   = 0;

  int          wr_cnt, sof_cnt, eof_cnt, b2b_cnt;
  logic [15:0] first_data, last_data;
  logic        eof_overflow, eof_frame_err, prev_w_en;
  int          line_wr [4];

  always #5 clk = ~clk;

  ov7670_capture #(.H_ACTIVE(4), .V_ACTIVE(2)) dut (
    .wclk      (clk),
    .wrst_n    (rst_n),
    .vsync     (vsync),
    .href      (href),
    .d         (d),
    .full      (full),
    .w_en      (w_en),
    .w_data    (w_data),
    .sof       (sof),
    .eof       (eof),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (w_en) begin
      wr_cnt++;
      if (wr_cnt == 1) first_data = w_data;
      last_data = w_data;
      if (prev_w_en) b2b_cnt++;
    end
    prev_w_en = w_en;
    if (sof) sof_cnt++;
    if (eof) begin
      eof_cnt++;
      eof_overflow  = overflow;
      eof_frame_err = frame_err;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_stats();
    wr_cnt = 0; sof_cnt = 0; eof_cnt = 0;
    first_data = '0; last_data = '0;
    eof_overflow = 1'b0; eof_frame_err = 1'b0;
    for (int i = 0; i < 4; i++) line_wr[i] = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      href = 1'b0;
      full = 1'b0;
    end
  endtask

  // Bytes 1..nbytes on one line; full asserted while driving byte index drop_j
  task automatic send_line(input int nbytes, input int drop_j);
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      href = 1'b1;
      d    = 8'(i + 1);
      full = (i == drop_j);
    end
  endtask

  task automatic frame(input int nlines, input int short_line, input int drop_line);
    int base;
    @(negedge clk);
    vsync = 1'b1;
    idle(3);
    vsync = 1'b0;
    idle(3);
    for (int l = 0; l < nlines; l++) begin
      base = wr_cnt;
      send_line((l == short_line) ? 7 : 8, (l == drop_line) ? 4 : -1);
      idle(3);
      if (l < 4) line_wr[l] = wr_cnt - base;
    end
    vsync = 1'b1;
    idle(5);
  endtask

  initial begin
    int waited;
    rst_n = 1'b1; vsync = 1'b0; href = 1'b0; full = 1'b0; d = '0;
    prev_w_en = 1'b0; b2b_cnt = 0;
    clear_stats();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_w_en", 32'(w_en), 0);
    check("rst_w_data", 32'(w_data), 0);
    check("rst_flags", {28'd0, sof, eof, overflow, frame_err}, 0);
    rst_n = 1'b1;

    // Clean 2x4 frame
    clear_stats();
    frame(2, -1, -1);
    check("t1_writes", wr_cnt, 8);
    check("t1_line0", line_wr[0], 4);
    check("t1_first", 32'(first_data), 32'h0102);
    check("t1_last", 32'(last_data), 32'h0708);
    check("t1_sof", sof_cnt, 1);
    check("t1_eof", eof_cnt, 1);
    check("t1_ferr", 32'(eof_frame_err), 0);

    // Reset released mid-line while vsync is low
    @(negedge clk);
    vsync = 1'b0;
    rst_n = 1'b0;
    clear_stats();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1'b1;
      href = 1'b1;
      d    = 8'(i + 1);
    end
    idle(3);
    send_line(8, -1);
    idle(3);
    check("t2_no_writes", wr_cnt, 0);
    check("t2_no_sof", sof_cnt, 0);
    frame(2, -1, -1);
    check("t2_writes", wr_cnt, 8);
    check("t2_sof", sof_cnt, 1);
    check("t2_ferr", 32'(eof_frame_err), 0);

    // FIFO full on pixel 2 of line 1
    clear_stats();
    frame(2, -1, 0);
    check("t3_writes", wr_cnt, 7);
    check("t3_line0", line_wr[0], 3);
    check("t3_ovf_at_eof", 32'(eof_overflow), 1);
    check("t3_ovf_sticky", 32'(overflow), 1);
    check("t3_ferr", 32'(eof_frame_err), 0);
    clear_stats();
    frame(2, -1, -1);
    check("t3_ovf_cleared", 32'(overflow), 0);
    check("t3b_writes", wr_cnt, 8);

    // Odd-length line
    clear_stats();
    frame(2, 0, -1);
    check("t4_line0", line_wr[0], 3);
    check("t4_line1", line_wr[1], 4);
    check("t4_ferr", 32'(eof_frame_err), 1);
    clear_stats();
    frame(2, -1, -1);
    check("t4_clean_ferr", 32'(eof_frame_err), 0);

    // Extra line, then href activity during vertical blanking
    clear_stats();
    frame(3, -1, -1);
    check("t5_writes", wr_cnt, 12);
    check("t5_ferr", 32'(eof_frame_err), 1);
    check("t5_ferr_held", 32'(frame_err), 1);
    clear_stats();
    send_line(8, -1);
    idle(3);
    send_line(8, -1);
    idle(3);
    check("t5_blank_writes", wr_cnt, 0);

    // Reset asserted while w_en is high
    @(negedge clk);
    vsync = 1'b0;
    idle(3);
    waited = 0;
    while (!w_en && waited < 12) begin
      @(negedge clk);
      href = 1'b1;
      d    = 8'(waited + 1);
      waited++;
    end
    check("t6_w_en_seen", 32'(w_en), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_w_en", 32'(w_en), 0);
    check("t6_w_data", 32'(w_data), 0);
    check("t6_flags", {28'd0, sof, eof, overflow, frame_err}, 0);
    idle(2);
    rst_n = 1'b1;

    check("no_back_to_back", b2b_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
